// File: rtl/axi_arb_pkg.sv
// Shared types and encodings for the two-master AXI4 arbiter.
// Optional build macro: AXI_ARB_RR_EN (round-robin arbitration).
package axi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4,
        ST_WRESP = 3'd5
    } state_t;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_arb_if.sv
// Full AXI4 bundle (AR, R, AW, W, B) with master/slave modports.
interface axi_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic                  arvalid, arready;
    logic [ID_W-1:0]       arid;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid, rready;
    logic [ID_W-1:0]       rid;
    logic [1:0]            rresp;
    logic [DATA_W-1:0]     rdata;
    logic                  rlast;

    logic                  awvalid, awready;
    logic [ID_W-1:0]       awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid, wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid, bready;
    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst,
        output rready,
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  arready, rvalid, rid, rresp, rdata, rlast,
        input  awready, wready, bvalid, bid, bresp
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        input  rready,
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output arready, rvalid, rid, rresp, rdata, rlast,
        output awready, wready, bvalid, bid, bresp
    );

endinterface

// File: rtl/axi_arb_grant.sv
// IDLE-state winner selection between IFU and LSU.
// AXI_ARB_RR_EN: alternate on conflict; otherwise LSU has fixed priority.
module axi_arb_grant
    import axi_arb_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_arb,
    input  logic i_ifu_rd,
    input  logic i_lsu_rd,
    input  logic i_lsu_wr,
    output logic o_valid,
    output logic o_mst,
    output logic o_wr
);
    logic w_lsu;

    assign w_lsu   = i_lsu_rd | i_lsu_wr;
    assign o_valid = i_ifu_rd | w_lsu;
    // A pending LSU write always beats the LSU's own read
    assign o_wr    = (o_mst == MST_LSU) && i_lsu_wr;

`ifdef AXI_ARB_RR_EN
    logic r_last;

    always_comb begin
        o_mst = MST_IFU;
        if (w_lsu && i_ifu_rd)
            o_mst = (r_last == MST_IFU) ? MST_LSU : MST_IFU;
        else if (w_lsu)
            o_mst = MST_LSU;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_last <= MST_IFU;
        else if (i_arb && o_valid)
            r_last <= o_mst;
    end
`else
    logic w_unused;

    assign o_mst    = w_lsu ? MST_LSU : MST_IFU;
    assign w_unused = ^{i_clk, i_rst_n, i_arb};
`endif

endmodule

// File: rtl/axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4 arbiter.
// One transaction in flight; AXI_ARB_RR_EN selects round-robin grant.
module axi_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    axi_arb_if.slave  s0,
    axi_arb_if.slave  s1,
    axi_arb_if.master m
);
    localparam int WB_W = DATA_W + DATA_W / 8 + 1;

    state_t            r_state, w_next;
    logic              r_mst;
    logic              w_gnt_vld, w_gnt_mst, w_gnt_wr;
    logic              w_sel_arvalid, w_sel_rready;
    logic [ID_W-1:0]   w_sel_arid;
    logic [ADDR_W-1:0] w_sel_araddr;
    logic [7:0]        w_sel_arlen;
    logic [2:0]        w_sel_arsize;
    logic [1:0]        w_sel_arburst;
    logic [WB_W-1:0]   w_w_beat;
    logic              w_unused;

    axi_arb_grant u_grant (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_arb    (r_state == ST_IDLE),
        .i_ifu_rd (s0.arvalid),
        .i_lsu_rd (s1.arvalid),
        .i_lsu_wr (s1.awvalid),
        .o_valid  (w_gnt_vld),
        .o_mst    (w_gnt_mst),
        .o_wr     (w_gnt_wr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mst   <= MST_IFU;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_gnt_vld)
                r_mst <= w_gnt_mst;
        end
    end

    assign w_sel_arvalid = (r_mst == MST_LSU) ? s1.arvalid : s0.arvalid;
    assign w_sel_arid    = (r_mst == MST_LSU) ? s1.arid    : s0.arid;
    assign w_sel_araddr  = (r_mst == MST_LSU) ? s1.araddr  : s0.araddr;
    assign w_sel_arlen   = (r_mst == MST_LSU) ? s1.arlen   : s0.arlen;
    assign w_sel_arsize  = (r_mst == MST_LSU) ? s1.arsize  : s0.arsize;
    assign w_sel_arburst = (r_mst == MST_LSU) ? s1.arburst : s0.arburst;
    assign w_sel_rready  = (r_mst == MST_LSU) ? s1.rready  : s0.rready;
    assign w_w_beat      = {s1.wdata, s1.wstrb, s1.wlast};

    // The IFU port is read-only; its write-side inputs are ignored
    assign w_unused = ^{s0.awvalid, s0.awid, s0.awaddr, s0.awlen,
                        s0.awsize, s0.awburst, s0.wvalid, s0.wdata,
                        s0.wstrb, s0.wlast, s0.bready};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:
                if (w_gnt_vld)
                    w_next = w_gnt_wr ? ST_WADDR : ST_RADDR;
            ST_RADDR:
                if (w_sel_arvalid && m.arready)
                    w_next = ST_RDATA;
            ST_RDATA:
                if (m.rvalid && w_sel_rready && m.rlast)
                    w_next = ST_IDLE;
            ST_WADDR:
                if (s1.awvalid && m.awready)
                    w_next = ST_WDATA;
            ST_WDATA:
                if (s1.wvalid && m.wready && s1.wlast)
                    w_next = ST_WRESP;
            ST_WRESP:
                if (m.bvalid && s1.bready)
                    w_next = ST_IDLE;
            default:
                w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        m.arvalid  = 1'b0;  m.arid    = '0;  m.araddr = '0;
        m.arlen    = '0;    m.arsize  = '0;  m.arburst = '0;
        m.rready   = 1'b0;
        m.awvalid  = 1'b0;  m.awid    = '0;  m.awaddr = '0;
        m.awlen    = '0;    m.awsize  = '0;  m.awburst = '0;
        m.wvalid   = 1'b0;  m.wdata   = '0;  m.wstrb  = '0;
        m.wlast    = 1'b0;  m.bready  = 1'b0;
        s0.arready = 1'b0;  s0.rvalid = 1'b0; s0.rid   = '0;
        s0.rresp   = '0;    s0.rdata  = '0;  s0.rlast = 1'b0;
        s0.awready = 1'b0;  s0.wready = 1'b0; s0.bvalid = 1'b0;
        s0.bid     = '0;    s0.bresp  = '0;
        s1.arready = 1'b0;  s1.rvalid = 1'b0; s1.rid   = '0;
        s1.rresp   = '0;    s1.rdata  = '0;  s1.rlast = 1'b0;
        s1.awready = 1'b0;  s1.wready = 1'b0; s1.bvalid = 1'b0;
        s1.bid     = '0;    s1.bresp  = '0;
        unique case (r_state)
            ST_RADDR: begin
                m.arvalid = w_sel_arvalid;
                m.arid    = w_sel_arid;
                m.araddr  = w_sel_araddr;
                m.arlen   = w_sel_arlen;
                m.arsize  = w_sel_arsize;
                m.arburst = w_sel_arburst;
                if (r_mst == MST_LSU) s1.arready = m.arready;
                else                  s0.arready = m.arready;
            end
            ST_RDATA: begin
                m.rready = w_sel_rready;
                if (r_mst == MST_LSU) begin
                    s1.rvalid = m.rvalid;  s1.rid   = m.rid;
                    s1.rresp  = m.rresp;   s1.rdata = m.rdata;
                    s1.rlast  = m.rlast;
                end else begin
                    s0.rvalid = m.rvalid;  s0.rid   = m.rid;
                    s0.rresp  = m.rresp;   s0.rdata = m.rdata;
                    s0.rlast  = m.rlast;
                end
            end
            ST_WADDR: begin
                m.awvalid  = s1.awvalid;
                m.awid     = s1.awid;
                m.awaddr   = s1.awaddr;
                m.awlen    = s1.awlen;
                m.awsize   = s1.awsize;
                m.awburst  = s1.awburst;
                s1.awready = m.awready;
            end
            ST_WDATA: begin
                m.wvalid  = s1.wvalid;
                {m.wdata, m.wstrb, m.wlast} = w_w_beat;
                s1.wready = m.wready;
            end
            ST_WRESP: begin
                s1.bvalid = m.bvalid;
                s1.bid    = m.bid;
                s1.bresp  = m.bresp;
                m.bready  = s1.bready;
            end
            default: ;
        endcase
    end

endmodule
